// File: rtl/hazard_pkg.sv
// +----------------------------------------------------------------------------+
// | hazard_pkg                                                                 |
// | Opcodes, format codes and scoreboard entry type for the decode interlock.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package hazard_pkg;

  localparam int REG_W = 3;

  localparam logic [1:0] FMT_J  = 2'd0;
  localparam logic [1:0] FMT_I1 = 2'd1;
  localparam logic [1:0] FMT_I2 = 2'd2;
  localparam logic [1:0] FMT_R  = 2'd3;

  localparam logic [REG_W-1:0] LINK_REG = 3'd7;

  localparam logic [4:0] OP_HALT  = 5'b00000;
  localparam logic [4:0] OP_NOP   = 5'b00001;
  localparam logic [4:0] OP_J     = 5'b00100;
  localparam logic [4:0] OP_JR    = 5'b00101;
  localparam logic [4:0] OP_JAL   = 5'b00110;
  localparam logic [4:0] OP_JALR  = 5'b00111;
  localparam logic [4:0] OP_ADDI  = 5'b01000;
  localparam logic [4:0] OP_SUBI  = 5'b01001;
  localparam logic [4:0] OP_XORI  = 5'b01010;
  localparam logic [4:0] OP_ANDNI = 5'b01011;
  localparam logic [4:0] OP_BEQZ  = 5'b01100;
  localparam logic [4:0] OP_BNEZ  = 5'b01101;
  localparam logic [4:0] OP_BLTZ  = 5'b01110;
  localparam logic [4:0] OP_BGEZ  = 5'b01111;
  localparam logic [4:0] OP_ST    = 5'b10000;
  localparam logic [4:0] OP_LD    = 5'b10001;
  localparam logic [4:0] OP_SLBI  = 5'b10010;
  localparam logic [4:0] OP_STU   = 5'b10011;
  localparam logic [4:0] OP_ROLI  = 5'b10100;
  localparam logic [4:0] OP_SLLI  = 5'b10101;
  localparam logic [4:0] OP_RORI  = 5'b10110;
  localparam logic [4:0] OP_SRLI  = 5'b10111;
  localparam logic [4:0] OP_LBI   = 5'b11000;
  localparam logic [4:0] OP_BTR   = 5'b11001;
  localparam logic [4:0] OP_SHF   = 5'b11010;
  localparam logic [4:0] OP_ALU   = 5'b11011;
  localparam logic [4:0] OP_SEQ   = 5'b11100;
  localparam logic [4:0] OP_SLT   = 5'b11101;
  localparam logic [4:0] OP_SLE   = 5'b11110;
  localparam logic [4:0] OP_SCO   = 5'b11111;

  typedef struct packed {
    logic             valid;
    logic             wr;
    logic [REG_W-1:0] dst;
    logic             is_load;
  } sb_entry_t;

  // True when a live, writing entry targets either enabled source register.
  function automatic logic entry_hit(input sb_entry_t e,
                                     input logic a_en, input logic [REG_W-1:0] a,
                                     input logic b_en, input logic [REG_W-1:0] b);
    return e.valid & e.wr & ((a_en & (a == e.dst)) | (b_en & (b == e.dst)));
  endfunction

endpackage

`default_nettype wire

// File: rtl/reg_use_decode.sv
// +----------------------------------------------------------------------------+
// | reg_use_decode                                                             |
// | Combinational format / source / destination extraction for the ID stage.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module reg_use_decode import hazard_pkg::*; #(
  parameter int NREG_BITS = 3
) (
  input  logic [15:0]          instr,
  output logic [1:0]           fmt,
  output logic                 rd_a_en,
  output logic [NREG_BITS-1:0] rd_a,
  output logic                 rd_b_en,
  output logic [NREG_BITS-1:0] rd_b,
  output logic                 wr_en,
  output logic [NREG_BITS-1:0] wr_dst,
  output logic                 is_load
);

  logic [4:0] w_op;
  assign w_op = instr[15:11];

  always_comb begin
    fmt     = FMT_J;
    rd_a_en = 1'b0;
    rd_a    = instr[10:8];
    rd_b_en = 1'b0;
    rd_b    = instr[7:5];
    wr_en   = 1'b0;
    wr_dst  = '0;
    is_load = 1'b0;
    case (w_op)
      OP_JAL: begin
        wr_en  = 1'b1;
        wr_dst = LINK_REG;
      end
      OP_ADDI, OP_SUBI, OP_XORI, OP_ANDNI,
      OP_ROLI, OP_SLLI, OP_RORI, OP_SRLI, OP_LD: begin
        fmt     = FMT_I1;
        rd_a_en = 1'b1;
        wr_en   = 1'b1;
        wr_dst  = instr[7:5];
        is_load = (w_op == OP_LD);
      end
      OP_ST: begin
        fmt     = FMT_I1;
        rd_a_en = 1'b1;
        rd_b_en = 1'b1;
      end
      OP_STU: begin
        fmt     = FMT_I1;
        rd_a_en = 1'b1;
        rd_b_en = 1'b1;
        wr_en   = 1'b1;
        wr_dst  = instr[10:8];
      end
      OP_LBI: begin
        fmt    = FMT_I2;
        wr_en  = 1'b1;
        wr_dst = instr[10:8];
      end
      OP_SLBI: begin
        fmt     = FMT_I2;
        rd_a_en = 1'b1;
        wr_en   = 1'b1;
        wr_dst  = instr[10:8];
      end
      OP_JR, OP_BEQZ, OP_BNEZ, OP_BLTZ, OP_BGEZ: begin
        fmt     = FMT_I2;
        rd_a_en = 1'b1;
      end
      OP_JALR: begin
        fmt     = FMT_I2;
        rd_a_en = 1'b1;
        wr_en   = 1'b1;
        wr_dst  = LINK_REG;
      end
      OP_BTR: begin
        fmt     = FMT_R;
        rd_a_en = 1'b1;
        wr_en   = 1'b1;
        wr_dst  = instr[4:2];
      end
      OP_SHF, OP_ALU, OP_SEQ, OP_SLT, OP_SLE, OP_SCO: begin
        fmt     = FMT_R;
        rd_a_en = 1'b1;
        rd_b_en = 1'b1;
        wr_en   = 1'b1;
        wr_dst  = instr[4:2];
      end
      // HALT, NOP, J and undefined opcodes use no registers.
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/hazard_stall_ctrl.sv
// +----------------------------------------------------------------------------+
// | hazard_stall_ctrl                                                          |
// | Decode-stage RAW interlock with a 3-entry EX/MEM/WB destination scoreboard.|
// | Optional macro HAZARD_FWD_EN: forwarding present, only load-use stalls.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module hazard_stall_ctrl import hazard_pkg::*; #(
  parameter int RF_BYPASS = 1,
  parameter int NREG_BITS = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] id_instr,
  input  logic        id_valid,
  input  logic        flush,
  input  logic        hold,
  output logic        stall,
  output logic        id_fire,
  output logic [1:0]  hz_src
);

  logic [1:0]           w_fmt;
  logic                 w_rd_a_en;
  logic [NREG_BITS-1:0] w_rd_a;
  logic                 w_rd_b_en;
  logic [NREG_BITS-1:0] w_rd_b;
  logic                 w_wr_en;
  logic [NREG_BITS-1:0] w_wr_dst;
  logic                 w_is_load;

  reg_use_decode #(.NREG_BITS(NREG_BITS)) u_decode (
    .instr   (id_instr),
    .fmt     (w_fmt),
    .rd_a_en (w_rd_a_en),
    .rd_a    (w_rd_a),
    .rd_b_en (w_rd_b_en),
    .rd_b    (w_rd_b),
    .wr_en   (w_wr_en),
    .wr_dst  (w_wr_dst),
    .is_load (w_is_load)
  );

  sb_entry_t r_ex, r_mem, r_wb;
  sb_entry_t w_dec;
  logic      r_run;
  logic      w_live, w_hazard, w_ex_hit, w_mw_hit, w_wb_hit;

  assign w_dec = '{valid: 1'b1, wr: w_wr_en, dst: w_wr_dst, is_load: w_is_load};

  generate
    if (RF_BYPASS == 0) begin : g_wb_chk
      assign w_wb_hit = entry_hit(r_wb, w_rd_a_en, w_rd_a, w_rd_b_en, w_rd_b);
    end else begin : g_wb_byp
      assign w_wb_hit = 1'b0;
    end
  endgenerate

`ifdef HAZARD_FWD_EN
  assign w_ex_hit = r_ex.is_load & entry_hit(r_ex, w_rd_a_en, w_rd_a, w_rd_b_en, w_rd_b);
  assign w_mw_hit = 1'b0;
`else
  assign w_ex_hit = entry_hit(r_ex, w_rd_a_en, w_rd_a, w_rd_b_en, w_rd_b);
  assign w_mw_hit = entry_hit(r_mem, w_rd_a_en, w_rd_a, w_rd_b_en, w_rd_b) | w_wb_hit;
`endif

  // r_run keeps the outputs quiet from reset assertion until the first edge after release.
  assign w_live   = r_run & id_valid & ~flush;
  assign w_hazard = w_ex_hit | w_mw_hit;
  assign stall    = w_live & w_hazard;
  assign id_fire  = w_live & ~w_hazard & ~hold;
  assign hz_src   = {w_mw_hit, w_ex_hit} & {2{w_live}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run <= 1'b0;
      r_ex  <= '0;
      r_mem <= '0;
      r_wb  <= '0;
    end else begin
      r_run <= 1'b1;
      if (!hold) begin
        r_wb  <= r_mem;
        r_mem <= r_ex;
        r_ex  <= id_fire ? w_dec : '0;
      end
    end
  end

  logic w_unused;
  assign w_unused = ^{w_fmt, r_ex.is_load, r_mem, r_wb, w_wb_hit};

endmodule

`default_nettype wire

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Decode-stage interlock controller for the 5-stage 16-bit pipeline.
- Classifies the ID instruction by format (J / I-format-1 / I-format-2 / R), extracts source and destination register usage, and tracks destinations of in-flight instructions in a 3-entry shift scoreboard (EX, MEM, WB).
- Asserts stall to freeze PC/IF-ID and inject bubbles into ID/EX on RAW hazards.

Parameters:
- RF_BYPASS, 1: 1 = register file writes before it reads in the same cycle, so the WB entry never causes a stall; 0 = the WB entry is also checked.
- NREG_BITS, 3: register index width (8 GPRs; R7 is the link register).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- id_instr  in  16  instruction in the IF/ID register
- id_valid  in  1  id_instr holds a real instruction
- flush  in  1  branch/jump resolved taken; the ID instruction is squashed this cycle
- hold  in  1  global memory-busy freeze; the whole pipeline holds
- stall  out  1  RAW hazard on the ID instruction; freeze PC and IF/ID
- id_fire  out  1  ID instruction advances into EX this cycle
- hz_src  out  2  debug: bit0 = EX match, bit1 = MEM/WB match

Behaviour:
- Reset (async, rst_n=0): all scoreboard entries invalid; stall=0, id_fire=0, hz_src=0. Release takes effect on the next clk edge.
- Format by opcode id_instr[15:11]:
  - J-format (0): HALT, NOP, J, JAL.
  - I-format-1 (1): ADDI/SUBI/XORI/ANDNI, shift-immediates, ST, LD, STU.
  - I-format-2 (2): LBI, SLBI, JR, JALR, branches.
  - R-format (3): BTR, ALU, shifts, SEQ/SLT/SLE/SCO.
  - Undefined opcodes are treated as J-format with no register use.
- Sources:
  - I-format-1: Rs=[10:8]; ST/STU also read [7:5].
  - I-format-2: JR/JALR/branches/SLBI read [10:8]; LBI reads nothing.
  - R-format: [10:8] and [7:5]; BTR reads only [10:8].
  - J-format: no sources.
- Destinations:
  - I-format-1 ALU ops and LD write [7:5]; STU writes [10:8]; ST writes nothing.
  - LBI/SLBI write [10:8]; JAL/JALR write R7; JR and branches write nothing.
  - R-format writes [4:2].
  - HALT/NOP write nothing.
- Entry = {valid, wr, dst[2:0], is_load}.
- Hazard: any source index equals the dst of a checked entry with valid&wr. Checked entries are EX and MEM, plus WB when RF_BYPASS=0.
- Output equations (combinational, same cycle):
  - stall = id_valid & ~flush & hazard.
  - id_fire = id_valid & ~flush & ~hazard & ~hold.
- Scoreboard update on posedge clk:
  - hold=1: all entries keep their values.
  - Otherwise: WB<=MEM, MEM<=EX, EX<=(id_fire ? decoded entry : bubble).
  - stall and flush both inject a bubble; flush has priority over stall.
- Latency: a producer fired in cycle N leaves EX at N+1 and MEM at N+2. A dependent instruction therefore stalls 2 cycles with RF_BYPASS=1, or 3 cycles with RF_BYPASS=0.
- Boundary conditions:
  - Source equal to a dst of an entry with wr=0 never stalls.
  - Both sources matching different entries produce a single stall.
  - hold during a stall keeps stall high and freezes the scoreboard.
  - Reset mid-stall clears all entries; stall=0 after reset.

Optional Feature:
- Macro HAZARD_FWD_EN.
- Defined: full EX->EX and MEM->EX forwarding exists, so only load-use stalls: hazard = EX entry valid & wr & is_load & dst matches a source. Stall is exactly 1 cycle; hz_src[1] is tied 0.
- Undefined: full interlock as specified above; is_load is stored but unused.

Decomposition:
- Shared package hazard_pkg:
  - opcode localparams;
  - format codes FMT_J=0, FMT_I1=1, FMT_I2=2, FMT_R=3;
  - scoreboard entry packed typedef;
  - LINK_REG=3'd7.
- Sub-module reg_use_decode (combinational): id_instr -> {fmt, rd_a_en, rd_a, rd_b_en, rd_b, wr_en, wr_dst, is_load}. The top holds the scoreboard and the stall logic.

Test Plan:
- ADD R1,R2,R3 (16'hDA64) then ADD R4,R1,R2 (16'hD950), RF_BYPASS=1, no fwd -> stall=1 for 2 cycles, hz_src 01 then 10, then id_fire=1.
- ADDI R1,R2,5 (16'h4225) then 16'hD950 with HAZARD_FWD_EN -> stall=0, no bubble. LD R1,R2,0 (16'h8A20) then 16'hD950 -> exactly 1 stall cycle.
- JAL (16'h3000) then JR R7,0 (16'h2F00), no fwd -> 2 stall cycles. ST after producer of [7:5] stalls; LBI after any producer never stalls.
- Dependent instruction in ID with flush=1 -> stall=0, id_fire=0, EX gets a bubble.
- hold=1 for 3 cycles during a stall -> stall stays 1, scoreboard frozen; after hold drops, stall clears on schedule.
- rst_n pulsed low asynchronously mid-stall -> stall=0 and id_fire=0 immediately; a following dependent instruction does not stall.
